// File: rtl/lsu_mem_ctrl.sv
// Load/store unit memory controller: accepts one aligned load/store from the pipeline,
// drives a word-aligned memory request until ack, then returns the extended load data.
//
// state | meaning
// IDLE  | waiting for a request; misaligned requests raise a one-cycle error pulse
// BUSY  | memory request outstanding, held stable until mem_ack_i
// RESP  | access finished; rdata_valid_o pulses for loads
module lsu_mem_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid_i,
  input  logic [3:0]  req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        err_misaligned_o,
  output logic        mem_req_o,
  output logic [3:0]  mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q;
  logic        mem_req_q;
  logic [3:0]  mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic        err_q;
  logic [1:0]  off_q;
  logic [2:0]  funct3_q;
  logic        load_q;

  logic        legal_mask;
  logic        misaligned;
  logic        accept;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;

  always_comb begin
    legal_mask = (req_we_i == 4'b0000) || (req_we_i == 4'b0001) ||
                 (req_we_i == 4'b0011) || (req_we_i == 4'b1111);
    misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                 ((req_funct3_i == 3'b010) && (req_addr_i[1:0] != 2'b00));
  end

  assign accept  = (state_q == IDLE) && req_valid_i && legal_mask && !misaligned;
  // stall is combinational so the pipeline freezes in the very cycle it is accepted
  assign stall_o = !reset && (accept || (state_q == BUSY));

  assign rd_shift = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b001:  rd_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b100:  rd_ext = {24'h000000, rd_shift[7:0]};
      3'b101:  rd_ext = {16'h0000, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 4'b0000;
      mem_addr_q    <= 32'h0;
      mem_wdata_q   <= 32'h0;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      err_q         <= 1'b0;
      off_q         <= 2'b00;
      funct3_q      <= 3'b000;
      load_q        <= 1'b0;
    end else begin
      err_q         <= 1'b0;
      rdata_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= req_we_i << req_addr_i[1:0];
            mem_addr_q  <= {req_addr_i[31:2], 2'b00};
            mem_wdata_q <= req_wdata_i << {req_addr_i[1:0], 3'b000};
            off_q       <= req_addr_i[1:0];
            funct3_q    <= req_funct3_i;
            load_q      <= (req_we_i == 4'b0000);
          end else if (req_valid_i && legal_mask && misaligned) begin
            err_q <= 1'b1;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state_q       <= RESP;
            mem_req_q     <= 1'b0;
            rdata_valid_q <= load_q;
            if (load_q) begin
              rdata_q <= rd_ext;
            end
          end
        end
        RESP: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_o        = mem_req_q;
  assign mem_we_o         = mem_we_q;
  assign mem_addr_o       = mem_addr_q;
  assign mem_wdata_o      = mem_wdata_q;
  assign rdata_o          = rdata_q;
  assign rdata_valid_o    = rdata_valid_q;
  assign err_misaligned_o = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: directed accesses push expected memory requests,
// load results and error pulses; a negedge monitor pops and compares them.
module tb_lsu_mem_ctrl;

  localparam int K_MEM = 0;
  localparam int K_RD  = 1;
  localparam int K_ERR = 2;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic [3:0]  req_we_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        stall_o;
  logic [31:0] rdata_o;
  logic        rdata_valid_o;
  logic        err_misaligned_o;
  logic        mem_req_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t q[$];
  exp_t cur;
  logic prev_req = 1'b0;

  lsu_mem_ctrl dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid_i),
    .req_we_i         (req_we_i),
    .req_funct3_i     (req_funct3_i),
    .req_addr_i       (req_addr_i),
    .req_wdata_i      (req_wdata_i),
    .stall_o          (stall_o),
    .rdata_o          (rdata_o),
    .rdata_valid_o    (rdata_valid_o),
    .err_misaligned_o (err_misaligned_o),
    .mem_req_o        (mem_req_o),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_ack_i        (mem_ack_i),
    .mem_rdata_i      (mem_rdata_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic exp_mem(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    exp_t e;
    e.kind = K_MEM; e.addr = addr; e.we = we; e.data = wd;
    q.push_back(e);
  endtask

  task automatic exp_rd(input logic [31:0] d);
    exp_t e;
    e.kind = K_RD; e.addr = 32'h0; e.we = 4'h0; e.data = d;
    q.push_back(e);
  endtask

  task automatic exp_err();
    exp_t e;
    e.kind = K_ERR; e.addr = 32'h0; e.we = 4'h0; e.data = 32'h0;
    q.push_back(e);
  endtask

  // Pops one expectation for an observed DUT event and checks its kind (and data for loads).
  task automatic pop_check(input int kind, input string name, input logic [31:0] act);
    exp_t e;
    vectors++;
    if (q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: unexpected event, value %h, nothing expected", name, act);
    end else begin
      e = q.pop_front();
      if (e.kind != kind || (kind == K_RD && act !== e.data)) begin
        miscompares++;
        $display("FAIL %s: got kind %0d value %h, expected kind %0d value %h",
                 name, kind, act, e.kind, e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_req = 1'b0;
    end else begin
      if (mem_req_o && !prev_req) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL mem_start: unexpected request addr %h, nothing expected", mem_addr_o);
        end else begin
          cur = q.pop_front();
          if (cur.kind != K_MEM || mem_addr_o !== cur.addr || mem_we_o !== cur.we ||
              mem_wdata_o !== cur.data) begin
            miscompares++;
            $display("FAIL mem_start: got addr %h we %b wdata %h, expected kind %0d addr %h we %b wdata %h",
                     mem_addr_o, mem_we_o, mem_wdata_o, cur.kind, cur.addr, cur.we, cur.data);
          end
        end
      end else if (mem_req_o) begin
        vectors++;
        if (mem_addr_o !== cur.addr || mem_we_o !== cur.we || mem_wdata_o !== cur.data) begin
          miscompares++;
          $display("FAIL mem_stable: got addr %h we %b wdata %h, expected addr %h we %b wdata %h",
                   mem_addr_o, mem_we_o, mem_wdata_o, cur.addr, cur.we, cur.data);
        end
      end
      if (rdata_valid_o) pop_check(K_RD, "load_result", rdata_o);
      if (err_misaligned_o) pop_check(K_ERR, "misaligned_pulse", 32'h1);
      prev_req = mem_req_o;
    end
  end

  // Presents one request, acks on the n_ack-th BUSY cycle, and counts stall cycles.
  task automatic run_access(input string name, input logic [3:0] we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [31:0] rd_mem, input int n_ack, input int exp_stall);
    int  stalls = 0;
    int  busy = 0;
    bit  done = 0;
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = we; req_funct3_i = f3;
    req_addr_i = addr; req_wdata_i = wd; mem_rdata_i = rd_mem;
    #1 if (stall_o) stalls++;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_req_o) begin
        if (stall_o) stalls++;
        busy++;
        mem_ack_i = (busy == n_ack);
      end else begin
        mem_ack_i = 1'b0;
        if (stall_o) stalls++;
        done = 1;
      end
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL %s_timeout: access still busy after 40 cycles, expected completion", name);
    end
    mem_ack_i = 1'b0;
    chk({name, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'h0;
    req_valid_i = 1'b1; req_we_i = 4'b1111; req_funct3_i = 3'b010;
    req_addr_i = 32'h100; req_wdata_i = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    chk("rst_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_mem_we", {28'h0, mem_we_o}, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_wdata", mem_wdata_o, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_rdata_valid", {31'h0, rdata_valid_o}, 32'h0);
    chk("rst_err", {31'h0, err_misaligned_o}, 32'h0);
    req_valid_i = 1'b0; reset = 1'b0;
    @(negedge clk);

    exp_mem(32'h100, 4'b1111, 32'hDEADBEEF);
    run_access("sw_100", 4'b1111, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 3, 4);

    exp_mem(32'h100, 4'b1000, 32'hA5000000);
    run_access("sb_103", 4'b0001, 3'b000, 32'h103, 32'h000000A5, 32'h0, 1, 2);

    exp_mem(32'h100, 4'b0000, 32'h0); exp_rd(32'hFFFFFFF4);
    run_access("lb_102", 4'b0000, 3'b000, 32'h102, 32'h0, 32'h12F45678, 1, 2);

    exp_mem(32'h100, 4'b0000, 32'h0); exp_rd(32'h000000F4);
    run_access("lbu_102", 4'b0000, 3'b100, 32'h102, 32'h0, 32'h12F45678, 2, 3);

    exp_mem(32'h100, 4'b0000, 32'h0); exp_rd(32'h00008001);
    run_access("lhu_102", 4'b0000, 3'b101, 32'h102, 32'h0, 32'h80010000, 1, 2);

    exp_mem(32'h100, 4'b0000, 32'h0); exp_rd(32'hFFFF8001);
    run_access("lh_102", 4'b0000, 3'b001, 32'h102, 32'h0, 32'h80010000, 1, 2);

    exp_mem(32'h104, 4'b0000, 32'h0); exp_rd(32'hCAFEF00D);
    run_access("lw_104", 4'b0000, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 2, 3);

    exp_mem(32'h100, 4'b1100, 32'hBEEF0000);
    run_access("sh_102", 4'b0011, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 2, 3);
    chk("rdata_hold_after_store", rdata_o, 32'hCAFEF00D);

    exp_err();
    run_access("lh_101_misaligned", 4'b0000, 3'b001, 32'h101, 32'h0, 32'h0, 1, 0);

    exp_err();
    run_access("sw_102_misaligned", 4'b1111, 3'b010, 32'h102, 32'h11111111, 32'h0, 1, 0);

    run_access("illegal_mask", 4'b0101, 3'b010, 32'h100, 32'h22222222, 32'h0, 1, 0);
    chk("rdata_hold_after_errors", rdata_o, 32'hCAFEF00D);

    exp_mem(32'h108, 4'b0000, 32'h0); exp_rd(32'h11223344);
    run_access("f3_011_as_lw", 4'b0000, 3'b011, 32'h108, 32'h0, 32'h11223344, 1, 2);

    // ack while idle must not produce anything
    @(negedge clk); mem_ack_i = 1'b1; mem_rdata_i = 32'h55555555;
    repeat (2) @(negedge clk);
    mem_ack_i = 1'b0;
    chk("idle_ack_rdata", rdata_o, 32'h11223344);

    // reset during BUSY abandons the load
    exp_mem(32'h200, 4'b0000, 32'h0);
    @(negedge clk);
    req_valid_i = 1'b1; req_we_i = 4'b0000; req_funct3_i = 3'b010;
    req_addr_i = 32'h200; req_wdata_i = 32'h0; mem_rdata_i = 32'hFFFFFFFF;
    @(posedge clk);
    #1 req_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_before_reset", {31'h0, mem_req_o}, 32'h1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_busy_stall", {31'h0, stall_o}, 32'h0);
    reset = 1'b0; mem_ack_i = 1'b1;
    @(negedge clk);
    mem_ack_i = 1'b0;
    chk("rst_late_ack_mem_req", {31'h0, mem_req_o}, 32'h0);
    chk("rst_late_ack_rdata", rdata_o, 32'h0);
    repeat (3) @(negedge clk);
    chk("rst_late_ack_valid", {31'h0, rdata_valid_o}, 32'h0);

    exp_mem(32'h100, 4'b0000, 32'h0); exp_rd(32'h000000AB);
    run_access("lbu_101_after_reset", 4'b0000, 3'b100, 32'h101, 32'h0, 32'h0000AB00, 1, 2);

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 SHALL have: req_valid_i  in  1  pipeline presents a load/store; req_we_i  in  4  store byte mask from control decoder (0000 load, 0001 SB, 0011 SH, 1111 SW); req_funct3_i  in  3  instruction funct3.
REQ-003 SHALL have: req_addr_i  in  32  byte address (ALU result); req_wdata_i  in  32  store data (rs2, right-justified).
REQ-004 SHALL have: stall_o  out  1  hold pipeline; rdata_o  out  32  extended load result; rdata_valid_o  out  1  load result valid; err_misaligned_o  out  1  misaligned access pulse.
REQ-005 SHALL have memory side: mem_req_o  out  1; mem_we_o  out  4; mem_addr_o  out  32 (word aligned); mem_wdata_o  out  32; mem_ack_i  in  1; mem_rdata_i  in  32.

Function
REQ-006 SHALL implement states IDLE, BUSY, RESP.
REQ-007 IDLE: if req_valid_i=1, access is aligned and req_we_i is a legal mask, SHALL register the request and go to BUSY; stall_o SHALL be 1 combinationally in this accept cycle.
REQ-008 Alignment: SH/LH/LHU (funct3 x01) SHALL need addr[0]=0; SW/LW (funct3 010) SHALL need addr[1:0]=00; byte accesses are always aligned.
REQ-009 Misaligned request in IDLE: no memory access, stall_o=0, err_misaligned_o SHALL be 1 for exactly the following cycle.
REQ-010 req_we_i values other than 0000/0001/0011/1111 SHALL be ignored (no access, no stall, no error).
REQ-011 BUSY: mem_req_o=1, stall_o=1; mem_addr_o, mem_we_o, mem_wdata_o SHALL stay stable until mem_ack_i=1.
REQ-012 mem_addr_o SHALL be {addr[31:2],2'b00}; mem_we_o SHALL be req_we_i shifted left by addr[1:0]; mem_wdata_o SHALL be req_wdata_i shifted left by 8*addr[1:0]; mem_we_o SHALL be 0000 for loads.
REQ-013 BUSY with mem_ack_i=1: SHALL go to RESP; for loads SHALL capture mem_rdata_i shifted right by 8*addr[1:0], extended per funct3, into rdata_o.
REQ-014 Extension: 000 LB sign-extend byte; 001 LH sign-extend half; 010 LW full word; 100 LBU zero-extend byte; 101 LHU zero-extend half; other funct3 with req_we_i=0000 SHALL behave as LW.
REQ-015 RESP: mem_req_o=0, stall_o=0, rdata_valid_o=1 for loads only (one cycle); req_valid_i SHALL be ignored; next state IDLE.
REQ-016 mem_ack_i SHALL be ignored in IDLE and RESP.
REQ-017 Latency: accept cycle + N BUSY cycles (ack on Nth) + 1 RESP cycle; minimum total 3 cycles; stall_o high for N+1 cycles.
REQ-018 rdata_o SHALL hold its value until the next load completes.

Reset
REQ-019 With reset=1 at a clock edge, state SHALL become IDLE and all registered outputs SHALL be 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, rdata_o, rdata_valid_o, err_misaligned_o.
REQ-020 stall_o SHALL be 0 while reset=1.
REQ-021 Reset mid-BUSY or mid-RESP SHALL abandon the access: no rdata_valid_o pulse, mem_req_o 0 from the next cycle, and a later mem_ack_i SHALL be ignored.

Verification
REQ-022 SW addr 0x100, wdata 0xDEADBEEF, ack on 3rd BUSY cycle -> mem_addr_o 0x100, mem_we_o 1111, mem_wdata_o 0xDEADBEEF, stall_o high 4 cycles, no rdata_valid_o.
REQ-023 SB addr 0x103, wdata 0x000000A5 -> mem_addr_o 0x100, mem_we_o 1000, mem_wdata_o 0xA5000000.
REQ-024 LB addr 0x102, mem_rdata_i 0x12F45678 -> rdata_o 0xFFFFFFF4, rdata_valid_o 1 in RESP; same with LBU -> 0x000000F4.
REQ-025 LHU addr 0x102, mem_rdata_i 0x80010000 -> rdata_o 0x00008001; LH -> 0xFFFF8001.
REQ-026 LH addr 0x101 -> err_misaligned_o 1-cycle pulse next cycle, mem_req_o never 1, stall_o 0.
REQ-027 Reset asserted during BUSY, then ack -> mem_req_o 0 next cycle, state IDLE, rdata_valid_o stays 0, rdata_o 0.
